// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one ram_controller user port among NUM_REQ requesters.
// Optional ISSUE-state watchdog is compiled in when ARB_TIMEOUT_EN is defined.
module ram_port_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         ack_rdata,
    output logic                          ack_err,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          ctrl_start,
    output logic                          ctrl_rw,
    output logic [ADDR_WIDTH-1:0]         ctrl_address,
    output logic [DATA_WIDTH-1:0]         ctrl_write_data,
    input  logic [DATA_WIDTH-1:0]         ctrl_read_data,
    input  logic                          ctrl_done
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RELEASE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          ptr_q, ptr_d;
    logic [GW-1:0]          grant_id_q, grant_id_d;
    logic                   ctrl_start_q, ctrl_start_d;
    logic                   ctrl_rw_q, ctrl_rw_d;
    logic [ADDR_WIDTH-1:0]  ctrl_address_q, ctrl_address_d;
    logic [DATA_WIDTH-1:0]  ctrl_write_data_q, ctrl_write_data_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [DATA_WIDTH-1:0]  ack_rdata_q, ack_rdata_d;
    logic                   busy_q, busy_d;

    logic                   win_vld;
    logic [GW-1:0]          win_idx;
    logic [GW-1:0]          cand;
    logic                   timeout;

    // First requester at or after ptr, wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = GW'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack_err_q, ack_err_d;

    // Fires on the ISSUE edge that would bring the count to TIMEOUT_CYCLES.
    assign timeout = (state_q == ISSUE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d     = cnt_q;
        ack_err_d = 1'b0;
        if (state_q == IDLE && win_vld) begin
            cnt_d = '0;
        end else if (state_q == ISSUE && !ctrl_done) begin
            if (timeout) ack_err_d = 1'b1;
            else         cnt_d     = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            ack_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign ack_err = ack_err_q;
`else
    assign timeout = 1'b0;
    assign ack_err = 1'b0;
`endif

    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        grant_id_d        = grant_id_q;
        ctrl_start_d      = ctrl_start_q;
        ctrl_rw_d         = ctrl_rw_q;
        ctrl_address_d    = ctrl_address_q;
        ctrl_write_data_d = ctrl_write_data_q;
        ack_d             = '0;
        ack_rdata_d       = ack_rdata_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d           = ISSUE;
                    grant_id_d        = win_idx;
                    ctrl_start_d      = 1'b1;
                    ctrl_rw_d         = req_rw[win_idx];
                    ctrl_address_d    = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    ctrl_write_data_d = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            ISSUE: begin
                // done wins over a coincident timeout
                if (ctrl_done || timeout) begin
                    state_d             = RELEASE;
                    ctrl_start_d        = 1'b0;
                    ack_d[grant_id_q]   = 1'b1;
                    ack_rdata_d         = ctrl_done ? ctrl_read_data : '0;
                    ptr_d               = GW'((int'(grant_id_q) + 1) % NUM_REQ);
                end
            end
            RELEASE: begin
                if (!ctrl_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            ptr_q             <= '0;
            grant_id_q        <= '0;
            ctrl_start_q      <= 1'b0;
            ctrl_rw_q         <= 1'b0;
            ctrl_address_q    <= '0;
            ctrl_write_data_q <= '0;
            ack_q             <= '0;
            ack_rdata_q       <= '0;
            busy_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            ptr_q             <= ptr_d;
            grant_id_q        <= grant_id_d;
            ctrl_start_q      <= ctrl_start_d;
            ctrl_rw_q         <= ctrl_rw_d;
            ctrl_address_q    <= ctrl_address_d;
            ctrl_write_data_q <= ctrl_write_data_d;
            ack_q             <= ack_d;
            ack_rdata_q       <= ack_rdata_d;
            busy_q            <= busy_d;
        end
    end

    assign ack             = ack_q;
    assign ack_rdata       = ack_rdata_q;
    assign grant_id        = grant_id_q;
    assign busy            = busy_q;
    assign ctrl_start      = ctrl_start_q;
    assign ctrl_rw         = ctrl_rw_q;
    assign ctrl_address    = ctrl_address_q;
    assign ctrl_write_data = ctrl_write_data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural controller + RAM, transaction-level reference model,
// directed scenarios followed by randomized multi-requester traffic.
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, req_rw;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   ack_rdata;
    logic            ack_err;
    logic [1:0]      grant_id;
    logic            busy, ctrl_start, ctrl_rw;
    logic [AW-1:0]   ctrl_address;
    logic [DW-1:0]   ctrl_write_data, ctrl_read_data;
    logic            ctrl_done;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem[256];
    logic [7:0] shadow[256];
    bit         stall = 1'b0;

    int got[8];
    int got_n, acks_n;

    ram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .ack_rdata(ack_rdata), .ack_err(ack_err),
        .grant_id(grant_id), .busy(busy), .ctrl_start(ctrl_start), .ctrl_rw(ctrl_rw),
        .ctrl_address(ctrl_address), .ctrl_write_data(ctrl_write_data),
        .ctrl_read_data(ctrl_read_data), .ctrl_done(ctrl_done)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Controller stand-in: random latency, done held 1-2 cycles, aborts if start drops.
    initial begin
        int cs, lat, hold;
        cs = 0; lat = 0; hold = 0;
        ctrl_done = 1'b0;
        ctrl_read_data = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                cs = 0;
                ctrl_done = 1'b0;
            end else begin
                case (cs)
                    0: if (ctrl_start) begin lat = $urandom_range(1, 4); cs = 1; end
                    1: begin
                        if (!ctrl_start) cs = 0;
                        else if (!stall) begin
                            lat--;
                            if (lat == 0) begin
                                ctrl_read_data = mem[ctrl_address];
                                if (ctrl_rw) mem[ctrl_address] = ctrl_write_data;
                                ctrl_done = 1'b1;
                                hold = $urandom_range(1, 2);
                                cs = 2;
                            end
                        end
                    end
                    default: begin
                        hold--;
                        if (hold == 0) begin ctrl_done = 1'b0; cs = 0; end
                    end
                endcase
            end
        end
    end

    // Reference model: one access in flight at a time, owner index, drain phase, rotating start point.
    int            m_owner = -1;
    bit            m_drain = 1'b0;
    int            m_ptr = 0;
    int            m_cnt = 0;
    logic [N-1:0]  e_ack = '0;
    logic [7:0]    e_rdata = '0, e_addr = '0, e_wdata = '0, e_mval = '0;
    logic [1:0]    e_gid = '0;
    logic          e_err = 1'b0, e_busy = 1'b0, e_start = 1'b0, e_rw = 1'b0, e_mchk = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int d = 0; d < N; d++) begin
            int k = (p + d) % N;
            if (((r >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    task automatic complete(input logic err, input logic [7:0] rd);
        e_start = 1'b0;
        e_ack   = 4'(1 << m_owner);
        e_err   = err;
        e_rdata = rd;
        if (!err) begin
            if (e_rw) shadow[e_addr] = e_wdata;
            else begin e_mchk = 1'b1; e_mval = shadow[e_addr]; end
        end
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_drain = 1'b1;
    endtask

    initial begin
        int w;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_drain = 1'b0; m_ptr = 0; m_cnt = 0;
                e_ack = '0; e_rdata = '0; e_err = 1'b0; e_gid = '0; e_busy = 1'b0;
                e_start = 1'b0; e_rw = 1'b0; e_addr = '0; e_wdata = '0; e_mchk = 1'b0;
            end else begin
                e_ack = '0; e_err = 1'b0; e_mchk = 1'b0;
                if (m_owner >= 0) begin
                    m_cnt++;
                    if (ctrl_done) complete(1'b0, ctrl_read_data);
`ifdef ARB_TIMEOUT_EN
                    else if (m_cnt >= TO) complete(1'b1, 8'h00);
`endif
                end else if (m_drain) begin
                    if (!ctrl_done) begin m_drain = 1'b0; e_busy = 1'b0; end
                end else begin
                    w = pick(req, m_ptr);
                    if (w >= 0) begin
                        m_owner = w; m_cnt = 0;
                        e_start = 1'b1; e_busy = 1'b1; e_gid = 2'(w);
                        e_rw    = req_rw[w[1:0]];
                        e_addr  = req_addr[w*AW +: AW];
                        e_wdata = req_wdata[w*DW +: DW];
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("ack", ack, e_ack);
        chk("ack_rdata", ack_rdata, e_rdata);
        chk("ack_err", ack_err, e_err);
        chk("grant_id", grant_id, e_gid);
        chk("busy", busy, e_busy);
        chk("ctrl_start", ctrl_start, e_start);
        chk("ctrl_rw", ctrl_rw, e_rw);
        chk("ctrl_address", ctrl_address, e_addr);
        chk("ctrl_write_data", ctrl_write_data, e_wdata);
        if (e_mchk) chk("rd_vs_mem", ack_rdata, e_mval);
    end

    task automatic set_cmd(input int i, input logic rw, input logic [7:0] a, input logic [7:0] d);
        req_rw[i[1:0]]       = rw;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_ack();
        int cyc = 0;
        while (ack == '0 && cyc < 60) begin tick(); cyc++; end
        if (ack == '0) begin total++; bad++; $display("FAIL wait_ack: no ack within %0d cycles", cyc); end
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((busy || ctrl_start || ctrl_done) && cyc < 60) begin tick(); cyc++; end
        if (busy) begin total++; bad++; $display("FAIL wait_idle: busy=%0b after %0d cycles", busy, cyc); end
    endtask

    // Records grant order at each ctrl_start rise until n acks; optionally re-raises acked requesters.
    task automatic collect(input int n, input bit rr);
        logic [N-1:0] again;
        logic         prev;
        int           cyc;
        got_n = 0; acks_n = 0; again = '0; prev = ctrl_start; cyc = 0;
        while (acks_n < n && cyc < 400) begin
            tick(); cyc++;
            if (ctrl_start && !prev && got_n < 8) begin got[got_n] = int'(grant_id); got_n++; end
            prev  = ctrl_start;
            req   = req | again;
            again = '0;
            if (ack != '0) begin
                acks_n++;
                req = req & ~ack;
                if (rr && got_n < n) again = ack;
            end
        end
        if (acks_n < n) begin total++; bad++; $display("FAIL collect: acks=%0d want %0d", acks_n, n); end
    endtask

    initial begin
        logic [N-1:0] cur;
        int           cyc;
        req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; shadow[i] = 8'h00; end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 4'b0000);
        chk("rst_start", ctrl_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gid", grant_id, 2'd0);
        rst_n = 1'b1;

        // write 0xA5 to 0x12 from requester 0
        set_cmd(0, 1'b1, 8'h12, 8'hA5); req[0] = 1'b1;
        tick();
        chk("t1_start", ctrl_start, 1'b1);
        chk("t1_addr", ctrl_address, 8'h12);
        wait_ack();
        chk("t1_ack", ack, 4'b0001);
        chk("t1_err", ack_err, 1'b0);
        req[0] = 1'b0;
        wait_idle();

        // read it back from requester 2
        set_cmd(2, 1'b0, 8'h12, 8'h00); req[2] = 1'b1;
        wait_ack();
        chk("t2_ack", ack, 4'b0100);
        chk("t2_rdata", ack_rdata, 8'hA5);
        req[2] = 1'b0;
        wait_idle();

        // after grant 2, requesters 1 and 3 together: 3 first
        set_cmd(1, 1'b0, 8'h12, 8'h00); set_cmd(3, 1'b0, 8'h30, 8'h00);
        req[1] = 1'b1; req[3] = 1'b1;
        collect(2, 1'b0);
        chk("t4_first", got[0], 3);
        chk("t4_second", got[1], 1);
        req = '0;
        wait_idle();

        // all four held from reset
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 8'(8'h20 + i), 8'h00);
        req = 4'b1111;
        tick(); tick();
        rst_n = 1'b1;
        collect(5, 1'b1);
        req = '0;
        chk("t3_ngrants", got_n, 5);
        chk("t3_g0", got[0], 0);
        chk("t3_g1", got[1], 1);
        chk("t3_g2", got[2], 2);
        chk("t3_g3", got[3], 3);
        chk("t3_g4", got[4], 0);
        wait_idle();

        // reset during ISSUE
        set_cmd(0, 1'b1, 8'h40, 8'h77); req[0] = 1'b1;
        tick();
        chk("t5_start", ctrl_start, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_start_rst", ctrl_start, 1'b0);
        chk("t5_ack_rst", ack, 4'b0000);
        req = 4'b0110;
        set_cmd(1, 1'b0, 8'h40, 8'h00); set_cmd(2, 1'b0, 8'h41, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        collect(1, 1'b0);
        chk("t5_first", got[0], 1);
        chk("t5_rdata", ack_rdata, 8'h00);
        req = '0;
        wait_idle();

`ifdef ARB_TIMEOUT_EN
        // stalled controller: watchdog acks with error, then the pending requester is served
        stall = 1'b1;
        set_cmd(3, 1'b1, 8'h50, 8'h33); req[3] = 1'b1;
        tick();
        chk("t6_start", ctrl_start, 1'b1);
        chk("t6_gid", grant_id, 2'd3);
        set_cmd(1, 1'b0, 8'h50, 8'h00); req[1] = 1'b1;
        cyc = 1;
        while (ack == '0 && cyc < 40) begin tick(); cyc++; end
        chk("t6_latency", cyc, TO);
        chk("t6_ack", ack, 4'b1000);
        chk("t6_err", ack_err, 1'b1);
        chk("t6_rdata", ack_rdata, 8'h00);
        req[3] = 1'b0;
        stall = 1'b0;
        collect(1, 1'b0);
        chk("t6_next", got[0], 1);
        chk("t6_next_rdata", ack_rdata, 8'h00);
        req = '0;
        wait_idle();
`endif

        // randomized traffic on a small address window to force read-after-write hits
        for (int c = 0; c < 3000; c++) begin
            tick();
            cur = ack;
            req = req & ~cur;
            for (int i = 0; i < N; i++) begin
                if (!req[i[1:0]] && !cur[i[1:0]] && $urandom_range(0, 3) == 0) begin
                    set_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
                    req[i[1:0]] = 1'b1;
                end else if (req[i[1:0]] && $urandom_range(0, 63) == 0) begin
                    req[i[1:0]] = 1'b0;
                end
            end
        end
        req = '0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
